// File: rtl/hsv_mask_bbox.sv
// HSV colour-threshold mask with per-frame bounding box and matched-pixel count.
// Streams one pixel per i_valid cycle; publishes box/count once per completed frame.
module hsv_mask_bbox #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int MIN_COUNT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_sof,
  input  logic [7:0]  i_H,
  input  logic [7:0]  i_S,
  input  logic [7:0]  i_V,
  input  logic [7:0]  i_h_lo,
  input  logic [7:0]  i_h_hi,
  input  logic [7:0]  i_s_min,
  input  logic [7:0]  i_v_min,
  output logic        o_mask,
  output logic        o_mask_valid,
  output logic [9:0]  o_xmin,
  output logic [9:0]  o_xmax,
  output logic [8:0]  o_ymin,
  output logic [8:0]  o_ymax,
  output logic [18:0] o_count,
  output logic        o_found,
  output logic        o_frame_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [9:0]  X_LAST  = 10'(IMG_W - 1);
  localparam logic [8:0]  Y_LAST  = 9'(IMG_H - 1);
  localparam logic [18:0] CNT_MAX = '1;
  localparam logic [18:0] MIN_CNT = 19'(MIN_COUNT);

  state_t      state;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [9:0]  acc_xmin, acc_xmax;
  logic [8:0]  acc_ymin, acc_ymax;
  logic [18:0] acc_count;

  logic        hue_ok, match, start, take, last;
  logic [9:0]  px;
  logic [8:0]  py;
  logic [9:0]  nxt_xmin, nxt_xmax;
  logic [8:0]  nxt_ymin, nxt_ymax;
  logic [18:0] nxt_count;

  always_comb begin
    if (i_h_lo <= i_h_hi)
      hue_ok = (i_H >= i_h_lo) && (i_H <= i_h_hi);
    else
      hue_ok = (i_H >= i_h_lo) || (i_H <= i_h_hi);
    match = hue_ok && (i_S >= i_s_min) && (i_V >= i_v_min);
  end

  // A start-of-frame pixel is always pixel (0,0), whatever the counters say.
  always_comb begin
    start = i_valid && i_sof;
    take  = i_valid && (i_sof || (state == ACTIVE));
    px    = i_sof ? '0 : x;
    py    = i_sof ? '0 : y;
    last  = (px == X_LAST) && (py == Y_LAST);
  end

  always_comb begin
    nxt_xmin  = acc_xmin;
    nxt_xmax  = acc_xmax;
    nxt_ymin  = acc_ymin;
    nxt_ymax  = acc_ymax;
    nxt_count = acc_count;
    if (start) begin
      nxt_xmin  = X_LAST;
      nxt_xmax  = '0;
      nxt_ymin  = Y_LAST;
      nxt_ymax  = '0;
      nxt_count = '0;
    end
    if (take && match) begin
      if (nxt_count != CNT_MAX) nxt_count = nxt_count + 19'd1;
      if (px < nxt_xmin) nxt_xmin = px;
      if (px > nxt_xmax) nxt_xmax = px;
      if (py < nxt_ymin) nxt_ymin = py;
      if (py > nxt_ymax) nxt_ymax = py;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mask       <= 1'b0;
      o_mask_valid <= 1'b0;
    end else begin
      o_mask       <= i_valid && match;
      o_mask_valid <= i_valid;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      acc_xmin  <= X_LAST;
      acc_xmax  <= '0;
      acc_ymin  <= Y_LAST;
      acc_ymax  <= '0;
      acc_count <= '0;
    end else begin
      acc_xmin  <= nxt_xmin;
      acc_xmax  <= nxt_xmax;
      acc_ymin  <= nxt_ymin;
      acc_ymax  <= nxt_ymax;
      acc_count <= nxt_count;
      if (take) begin
        if (px == X_LAST) begin
          x <= '0;
          y <= (py == Y_LAST) ? '0 : py + 9'd1;
        end else begin
          x <= px + 10'd1;
          y <= py;
        end
      end
      if (start)
        state <= last ? REPORT : ACTIVE;
      else begin
        case (state)
          ACTIVE:  if (take && last) state <= REPORT;
          REPORT:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // A sof arriving during REPORT restarts accumulation on the same edge; the
  // report still publishes the pre-edge accumulator values of the finished frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_xmin       <= '0;
      o_xmax       <= '0;
      o_ymin       <= '0;
      o_ymax       <= '0;
      o_count      <= '0;
      o_found      <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= (state == REPORT);
      if (state == REPORT) begin
        o_count <= acc_count;
        o_found <= (acc_count >= MIN_CNT);
        if (acc_count == '0) begin
          o_xmin <= '0;
          o_xmax <= '0;
          o_ymin <= '0;
          o_ymax <= '0;
        end else begin
          o_xmin <= acc_xmin;
          o_xmax <= acc_xmax;
          o_ymin <= acc_ymin;
          o_ymax <= acc_ymax;
        end
      end
    end
  end

endmodule

// File: tb/tb_hsv_mask_bbox.sv
// Scoreboard bench for hsv_mask_bbox: randomized frames, reference model from the
// matching/box rules, monitor pops expected mask bits and frame results.
`timescale 1ns/1ps
module tb_hsv_mask_bbox;

  localparam int W    = 112;
  localparam int H    = 64;
  localparam int MINC = 64;
  localparam int NPIX = W * H;

  typedef struct packed {
    logic [9:0]  xmin;
    logic [9:0]  xmax;
    logic [8:0]  ymin;
    logic [8:0]  ymax;
    logic [18:0] count;
    logic        found;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, sof;
  logic [7:0]  ph, ps, pv, hlo, hhi, smin, vmin;
  logic        mask, mask_valid, found, frame_done;
  logic [9:0]  xmin, xmax;
  logic [8:0]  ymin, ymax;
  logic [18:0] count;

  always #5 clk = ~clk;

  hsv_mask_bbox #(.IMG_W(W), .IMG_H(H), .MIN_COUNT(MINC)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_sof(sof),
    .i_H(ph), .i_S(ps), .i_V(pv),
    .i_h_lo(hlo), .i_h_hi(hhi), .i_s_min(smin), .i_v_min(vmin),
    .o_mask(mask), .o_mask_valid(mask_valid),
    .o_xmin(xmin), .o_xmax(xmax), .o_ymin(ymin), .o_ymax(ymax),
    .o_count(count), .o_found(found), .o_frame_done(frame_done)
  );

  int   tests = 0;
  int   fails = 0;
  bit   mask_q[$];
  res_t frame_q[$];
  res_t held;

  logic [7:0] fh[NPIX];
  logic [7:0] fs[NPIX];
  logic [7:0] fv[NPIX];

  bit m_active = 1'b0;
  int m_idx = 0;
  int mxs[$];
  int mys[$];

  function automatic void check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void check_res(string name, res_t exp);
    res_t act;
    act = '{xmin, xmax, ymin, ymax, count, found};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got box(%0d,%0d,%0d,%0d) count %0d found %0d, expected box(%0d,%0d,%0d,%0d) count %0d found %0d",
               name, act.xmin, act.xmax, act.ymin, act.ymax, act.count, act.found,
               exp.xmin, exp.xmax, exp.ymin, exp.ymax, exp.count, exp.found);
    end
  endfunction

  // Hue test as a circular distance: H lies in [lo, hi] walking upward from lo.
  function automatic bit ref_match(logic [7:0] h, logic [7:0] s, logic [7:0] v);
    int span, off;
    span = (int'(hhi) - int'(hlo) + 256) % 256;
    off  = (int'(h) - int'(hlo) + 256) % 256;
    return (s >= smin) && (v >= vmin) && (off <= span);
  endfunction

  function automatic res_t frame_result();
    res_t r;
    r = '0;
    if (mxs.size() > 0) begin
      r.xmin = 10'(W - 1); r.ymin = 9'(H - 1);
      foreach (mxs[i]) begin
        if (mxs[i] < r.xmin) r.xmin = 10'(mxs[i]);
        if (mxs[i] > r.xmax) r.xmax = 10'(mxs[i]);
        if (mys[i] < r.ymin) r.ymin = 9'(mys[i]);
        if (mys[i] > r.ymax) r.ymax = 9'(mys[i]);
      end
    end
    r.count = 19'(mxs.size());
    r.found = (mxs.size() >= MINC);
    return r;
  endfunction

  task automatic drive_pixel(logic [7:0] h, logic [7:0] s, logic [7:0] v, bit first);
    bit m;
    valid = 1'b1; sof = first; ph = h; ps = s; pv = v;
    m = ref_match(h, s, v);
    mask_q.push_back(m);
    if (first) begin
      m_active = 1'b1; m_idx = 0; mxs.delete(); mys.delete();
    end
    if (m_active) begin
      if (m) begin
        mxs.push_back(m_idx % W);
        mys.push_back(m_idx / W);
      end
      m_idx++;
      if (m_idx == NPIX) begin
        frame_q.push_back(frame_result());
        m_active = 1'b0;
      end
    end
    @(negedge clk);
    valid = 1'b0; sof = 1'b0;
  endtask

  task automatic send_pixels(int n, int gap_pct);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < gap_pct) @(negedge clk);
      drive_pixel(fh[i], fs[i], fv[i], i == 0);
    end
  endtask

  task automatic idle(int n);
    valid = 1'b0; sof = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // mode 0: 10x10 block at x=100..109,y=50..59; 1: 20 scattered matches with
  // wrapped hue; 2: no matches; 3: fully random thresholds and pixels.
  task automatic gen_frame(int mode);
    int x, y, k;
    bit in;
    case (mode)
      0, 2: begin hlo = 8'd20;  hhi = 8'd40; smin = 8'd100; vmin = 8'd100; end
      1:    begin hlo = 8'd200; hhi = 8'd10; smin = 8'd100; vmin = 8'd100; end
      default: begin
        hlo = 8'($urandom); hhi = 8'($urandom);
        smin = 8'($urandom_range(0, 200)); vmin = 8'($urandom_range(0, 200));
      end
    endcase
    for (int i = 0; i < NPIX; i++) begin
      x = i % W; y = i / W;
      fv[i] = 8'($urandom);
      if (mode == 3) begin
        fh[i] = 8'($urandom); fs[i] = 8'($urandom);
      end else begin
        in = (mode == 0) ? (x >= 100 && x <= 109 && y >= 50 && y <= 59)
           : (mode == 1) ? (i % 359 == 7) : 1'b0;
        if (in) begin
          k = $urandom_range(0, 66);
          fh[i] = (mode == 1) ? 8'((k <= 55) ? 200 + k : k - 56) : 8'($urandom_range(20, 40));
          fs[i] = 8'($urandom_range(100, 255));
          fv[i] = 8'($urandom_range(100, 255));
        end else if ($urandom_range(0, 1) == 0 || mode == 0) begin
          fh[i] = 8'($urandom); fs[i] = 8'($urandom_range(0, 99));
        end else begin
          fh[i] = 8'($urandom_range(50, 190)); fs[i] = 8'($urandom_range(100, 255));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    bit e;
    if (!rst) begin
      if (mask_valid) begin
        check("mask_expected_pending", mask_q.size() > 0, 1);
        if (mask_q.size() > 0) begin
          e = mask_q.pop_front();
          check("mask", mask, e);
        end
      end
      if (frame_done) begin
        check("frame_done_expected", frame_q.size() > 0, 1);
        if (frame_q.size() > 0) held = frame_q.pop_front();
      end
      check_res("results_held", held);
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; sof = 1'b0;
    ph = '0; ps = '0; pv = '0; hlo = '0; hhi = '0; smin = '0; vmin = '0;
    held = '0;
    @(negedge clk);
    check_res("reset_state", '0);
    check("reset_mask_valid", mask_valid, 0);
    check("reset_frame_done", frame_done, 0);
    #2 rst = 1'b0;
    @(negedge clk);

    // Hue wrap-around while idle: expect 1,1,0.
    hlo = 8'd240; hhi = 8'd15; smin = 8'd50; vmin = 8'd50;
    drive_pixel(8'd250, 8'd255, 8'd255, 1'b0);
    drive_pixel(8'd5,   8'd255, 8'd255, 1'b0);
    drive_pixel(8'd100, 8'd255, 8'd255, 1'b0);
    idle(3);

    gen_frame(0);
    send_pixels(NPIX, 0);
    idle(4);
    send_pixels(NPIX, 50);
    idle(4);

    // Back-to-back: the no-match frame's sof lands in the report cycle.
    gen_frame(1);
    send_pixels(NPIX, 0);
    gen_frame(2);
    send_pixels(NPIX, 0);
    idle(4);

    // Mid-frame sof at (100,40) restarts without a report.
    gen_frame(0);
    send_pixels(40 * W + 100, 0);
    send_pixels(NPIX, 0);
    idle(4);

    // Reset mid-frame clears outputs immediately; the partial frame never reports.
    gen_frame(3);
    send_pixels(3000, 0);
    #2 rst = 1'b1;
    held = '0; m_active = 1'b0; mask_q.delete();
    #1;
    check_res("reset_mid_outputs", '0);
    check("reset_mid_mask_valid", mask_valid, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    send_pixels(NPIX, 30);
    idle(10);

    check("mask_queue_drained", mask_q.size(), 0);
    check("frame_queue_drained", frame_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hsv_mask_bbox.md
HSV_MASK_BBOX -- requirements
Module: hsv_mask_bbox

Interface
REQ-001 SHALL have parameter IMG_W, default 640, pixels per line.
REQ-002 SHALL have parameter IMG_H, default 480, lines per frame.
REQ-003 SHALL have parameter MIN_COUNT, default 64, minimum matched pixels for a valid detection.
REQ-004 SHALL have port i_clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port i_rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_valid  in  1  HSV pixel present this cycle.
REQ-007 SHALL have port i_sof  in  1  start of frame, qualified by i_valid, marks pixel (0,0).
REQ-008 SHALL have ports i_H, i_S, i_V  in  8 each  pixel hue/saturation/value.
REQ-009 SHALL have ports i_h_lo, i_h_hi, i_s_min, i_v_min  in  8 each  match thresholds, sampled per pixel.
REQ-010 SHALL have port o_mask  out  1  registered match result.
REQ-011 SHALL have port o_mask_valid  out  1  o_mask qualifier.
REQ-012 SHALL have ports o_xmin, o_xmax  out  10 each  bounding-box columns of last completed frame.
REQ-013 SHALL have ports o_ymin, o_ymax  out  9 each  bounding-box rows of last completed frame.
REQ-014 SHALL have port o_count  out  19  matched-pixel count of last completed frame.
REQ-015 SHALL have port o_found  out  1  o_count >= MIN_COUNT for last completed frame.
REQ-016 SHALL have port o_frame_done  out  1  one-cycle pulse when results update.

Function
REQ-017 SHALL match when S >= i_s_min, V >= i_v_min, and hue in range: if i_h_lo <= i_h_hi then i_h_lo <= H <= i_h_hi, else H >= i_h_lo or H <= i_h_hi (hue wrap).
REQ-018 SHALL present o_mask/o_mask_valid exactly 1 cycle after the accepted pixel; o_mask_valid=0 when i_valid=0.
REQ-019 SHALL run FSM IDLE -> ACTIVE on i_valid&i_sof; ACTIVE -> REPORT after pixel (IMG_W-1, IMG_H-1); REPORT -> IDLE after one cycle.
REQ-020 SHALL ignore pixels (no accumulation, o_mask_valid still asserted) while IDLE without i_sof.
REQ-021 SHALL keep column counter x (0..IMG_W-1) and row counter y (0..IMG_H-1); x wraps to 0 and y increments on accepted pixel at x=IMG_W-1.
REQ-022 SHALL, on i_valid&i_sof in any state, set pixel to (0,0), clear accumulators, then accumulate that pixel (mid-frame sof restarts frame, no report).
REQ-023 SHALL per matched pixel: count+1, xmin=min, xmax=max, ymin=min, ymax=max; accumulators start at xmin=IMG_W-1, xmax=0, ymin=IMG_H-1, ymax=0, count=0.
REQ-024 SHALL in REPORT copy accumulators to outputs, set o_found, pulse o_frame_done; if count=0 outputs box as all zeros.
REQ-025 SHALL saturate count at 2^19-1.
REQ-026 SHALL hold outputs stable between o_frame_done pulses.
REQ-027 SHALL accept i_valid gaps of any length without losing position.

Reset
REQ-028 SHALL on i_rst asynchronously force FSM=IDLE, x=y=0, accumulators to start values, and all outputs 0.
REQ-029 SHALL treat reset mid-frame as frame discarded; first i_sof after release starts fresh.

Verification
REQ-030 SHALL cover: full 640x480 frame, matching 10x10 block at x=100..109, y=50..59 -> o_frame_done once, box (100,109,50,59), o_count=100, o_found=1.
REQ-031 SHALL cover: thresholds h_lo=240, h_hi=15; pixels H=250, H=5, H=100 with S,V max -> o_mask 1,1,0 each one cycle later.
REQ-032 SHALL cover: frame with 20 matches, MIN_COUNT=64 -> o_count=20, o_found=0; frame with no matches -> box zeros, o_count=0.
REQ-033 SHALL cover: i_sof reasserted at pixel (300,200) -> no o_frame_done, results reflect only the restarted frame.
REQ-034 SHALL cover: i_rst pulse mid-frame -> outputs 0 immediately, no o_frame_done until next complete frame.
REQ-035 SHALL cover: random i_valid gaps (50% duty) over full frame -> results identical to gap-free run.
